// File: rtl/mat_result_sink_if.sv
// Handshake bundle between the matrix multiplier, the result sink and its consumer.
// master = producer/consumer side (drives beats, accepts head); slave = the sink itself.
interface mat_result_sink_if #(
  parameter int unsigned inWidth    = 11,
  parameter int unsigned outWidth   = 8,
  parameter int unsigned levelWidth = 3
);

  logic [inWidth-1:0]    in;
  logic                  valid_in;
  logic                  last_in;
  logic                  ready_in;
  logic [outWidth-1:0]   out;
  logic                  valid_out;
  logic                  last_out;
  logic                  ready_out;
  logic [levelWidth-1:0] level;
  logic                  err;

  modport master (
    output in,
    output valid_in,
    output last_in,
    output ready_out,
    input  ready_in,
    input  out,
    input  valid_out,
    input  last_out,
    input  level,
    input  err
  );

  modport slave (
    input  in,
    input  valid_in,
    input  last_in,
    input  ready_out,
    output ready_in,
    output out,
    output valid_out,
    output last_out,
    output level,
    output err
  );

endinterface

// File: rtl/mat_result_sink.sv
// Result sink: FWFT FIFO with narrowing at push and N*N-beat frame checking.
// Define RESULT_SAT_EN to saturate oversized elements instead of truncating them.
module mat_result_sink #(
  parameter int unsigned elementsNum = 4,
  parameter int unsigned dataWidth   = 4,
  parameter int unsigned depth       = 4,
  parameter int unsigned outWidth    = 8
) (
  input logic              clk,
  input logic              rst,
  mat_result_sink_if.slave bus
);

  localparam int unsigned RW    = dataWidth * 2 + $clog2(elementsNum) + 1;
  localparam int unsigned PW    = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned LW    = $clog2(depth) + 1;
  localparam int unsigned EW    = outWidth + 1;
  localparam int unsigned FRAME = elementsNum * elementsNum;
  localparam int unsigned BW    = (FRAME > 1) ? $clog2(FRAME) : 1;

  localparam logic [LW-1:0] LevelFull = LW'(depth);
  localparam logic [BW-1:0] BcntLast  = BW'(FRAME - 1);

  logic [EW-1:0]       mem [depth];
  logic [PW-1:0]       wptr_q, rptr_q;
  logic [LW-1:0]       level_q, level_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic                err_q, err_d;
  logic [EW-1:0]       hold_q;
  logic [EW-1:0]       head;
  logic [outWidth-1:0] narrow;
  logic                ready_in, valid_out, push, pop;
  logic [RW-1:0]       din;

  assign din       = bus.in;
  assign ready_in  = (level_q != LevelFull);
  assign valid_out = (level_q != '0);
  assign push      = bus.valid_in && ready_in;
  assign pop       = valid_out && bus.ready_out;
  assign head      = mem[rptr_q];

  always_comb begin
    narrow = din[outWidth-1:0];
`ifdef RESULT_SAT_EN
    if (RW > outWidth) begin
      if ((din >> outWidth) != '0) begin
        narrow = '1;
      end
    end
`endif
  end

  // Storage needs no reset: only entries between rptr and wptr are ever presented.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= {bus.last_in, narrow};
    end
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // A last on the terminal beat is the only legal end; either mismatch flags err and restarts.
  always_comb begin
    bcnt_d = bcnt_q;
    err_d  = err_q;
    if (push) begin
      if (bus.last_in || (bcnt_q == BcntLast)) begin
        bcnt_d = '0;
        if (bus.last_in != (bcnt_q == BcntLast)) begin
          err_d = 1'b1;
        end
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      bcnt_q  <= '0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
        hold_q <= head;
      end
      level_q <= level_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
    end
  end

  // When empty, present the last popped entry so out stays quiet and resets to zero.
  assign bus.out       = valid_out ? head[outWidth-1:0] : hold_q[outWidth-1:0];
  assign bus.last_out  = valid_out ? head[outWidth] : hold_q[outWidth];
  assign bus.valid_out = valid_out;
  assign bus.ready_in  = ready_in;
  assign bus.level     = level_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mat_result_sink.sv
// Directed bench for mat_result_sink (N=4, dataWidth=4, depth=4, outWidth=8, RW=11).
module tb_mat_result_sink;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mat_result_sink_if #(.inWidth(11), .outWidth(8), .levelWidth(3)) bus ();

  mat_result_sink #(
    .elementsNum(4),
    .dataWidth  (4),
    .depth      (4),
    .outWidth   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef RESULT_SAT_EN
  localparam logic [7:0] Sat1F0 = 8'hFF;
`else
  localparam logic [7:0] Sat1F0 = 8'hF0;
`endif

  typedef struct {
    logic        vin;
    logic [10:0] din;
    logic        lin;
    logic        rout;
    logic        evalid;
    logic [7:0]  eout;
    logic        elast;
    logic        erdy;
    logic [2:0]  elevel;
    logic        eerr;
  } vec_t;

  vec_t vecs [64];
  int   nv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic evalid, input logic [7:0] eout,
                          input logic elast, input logic erdy, input logic [2:0] elevel,
                          input logic eerr);
    chk({tag, " valid_out"}, int'(bus.valid_out), int'(evalid));
    if (evalid) begin
      chk({tag, " out"}, int'(bus.out), int'(eout));
      chk({tag, " last_out"}, int'(bus.last_out), int'(elast));
    end
    chk({tag, " ready_in"}, int'(bus.ready_in), int'(erdy));
    chk({tag, " level"}, int'(bus.level), int'(elevel));
    chk({tag, " err"}, int'(bus.err), int'(eerr));
  endtask

  function automatic void add(input logic vin, input logic [10:0] din, input logic lin,
                              input logic rout, input logic evalid, input logic [7:0] eout,
                              input logic elast, input logic erdy, input logic [2:0] elevel,
                              input logic eerr);
    vecs[nv] = '{vin, din, lin, rout, evalid, eout, elast, erdy, elevel, eerr};
    nv++;
  endfunction

  task automatic step(input logic vin, input logic [10:0] d, input logic lin, input logic rout);
    bus.valid_in  = vin;
    bus.in        = d;
    bus.last_in   = lin;
    bus.ready_out = rout;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    nv            = 0;
    rst           = 1'b1;
    bus.valid_in  = 1'b0;
    bus.in        = '0;
    bus.last_in   = 1'b0;
    bus.ready_out = 1'b0;

    // Frame of 0..15 with consumer always ready: one-cycle latency, level stays 1.
    for (int k = 0; k < 16; k++) begin
      add(1'b1, 11'(k), (k == 15), 1'b1, 1'b1, 8'(k), (k == 15), 1'b1, 3'd1, 1'b0);
    end
    add(1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 3'd0, 1'b0);
    // Backpressure: fill to 4, 5th beat held until a slot frees.
    add(1'b1, 11'd16, 1'b0, 1'b0, 1'b1, 8'd16, 1'b0, 1'b1, 3'd1, 1'b0);
    add(1'b1, 11'd17, 1'b0, 1'b0, 1'b1, 8'd16, 1'b0, 1'b1, 3'd2, 1'b0);
    add(1'b1, 11'd18, 1'b0, 1'b0, 1'b1, 8'd16, 1'b0, 1'b1, 3'd3, 1'b0);
    add(1'b1, 11'd19, 1'b0, 1'b0, 1'b1, 8'd16, 1'b0, 1'b0, 3'd4, 1'b0);
    add(1'b1, 11'd20, 1'b0, 1'b0, 1'b1, 8'd16, 1'b0, 1'b0, 3'd4, 1'b0);
    add(1'b1, 11'd20, 1'b0, 1'b1, 1'b1, 8'd17, 1'b0, 1'b1, 3'd3, 1'b0);
    add(1'b1, 11'd20, 1'b0, 1'b1, 1'b1, 8'd18, 1'b0, 1'b1, 3'd3, 1'b0);
    add(1'b0, 11'd0,  1'b0, 1'b1, 1'b1, 8'd19, 1'b0, 1'b1, 3'd2, 1'b0);
    add(1'b0, 11'd0,  1'b0, 1'b1, 1'b1, 8'd20, 1'b0, 1'b1, 3'd1, 1'b0);
    add(1'b0, 11'd0,  1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b1, 3'd0, 1'b0);
    // Narrowing of oversized values (beats 6 and 7 of the frame).
    add(1'b1, 11'h3FF, 1'b0, 1'b0, 1'b1, 8'hFF,  1'b0, 1'b1, 3'd1, 1'b0);
    add(1'b1, 11'h1F0, 1'b0, 1'b1, 1'b1, Sat1F0, 1'b0, 1'b1, 3'd1, 1'b0);
    add(1'b0, 11'd0,   1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 3'd0, 1'b0);
    // Remaining 9 beats close the frame correctly.
    for (int k = 21; k < 30; k++) begin
      add(1'b1, 11'(k), (k == 29), 1'b1, 1'b1, 8'(k), (k == 29), 1'b1, 3'd1, 1'b0);
    end
    add(1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 3'd0, 1'b0);

    #12;
    chk_outs("reset", 1'b0, 8'd0, 1'b0, 1'b1, 3'd0, 1'b0);
    chk("reset out", int'(bus.out), 0);
    chk("reset last_out", int'(bus.last_out), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    for (int i = 0; i < nv; i++) begin
      step(vecs[i].vin, vecs[i].din, vecs[i].lin, vecs[i].rout);
      chk_outs($sformatf("vec%0d", i), vecs[i].evalid, vecs[i].eout, vecs[i].elast,
               vecs[i].erdy, vecs[i].elevel, vecs[i].eerr);
    end

    // Early last on beat 10, then a correct frame: err sticks.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 11'(100 + i), (i == 9), 1'b1);
      chk_outs($sformatf("early%0d", i), 1'b1, 8'(100 + i), (i == 9), 1'b1, 3'd1, (i == 9));
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 11'(i), (i == 15), 1'b1);
      chk_outs($sformatf("sticky%0d", i), 1'b1, 8'(i), (i == 15), 1'b1, 3'd1, 1'b1);
    end

    // Reset clears err; then 16 beats without last.
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk_outs("rst2", 1'b0, 8'd0, 1'b0, 1'b1, 3'd0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 11'(200 + i), 1'b0, 1'b1);
      chk_outs($sformatf("nolast%0d", i), 1'b1, 8'(200 + i), 1'b0, 1'b1, 3'd1, (i == 15));
    end
    step(1'b1, 11'd50, 1'b0, 1'b1);
    chk_outs("beat17", 1'b1, 8'd50, 1'b0, 1'b1, 3'd1, 1'b1);
    step(1'b0, 11'd0, 1'b0, 1'b1);
    chk_outs("drain17", 1'b0, 8'd0, 1'b0, 1'b1, 3'd0, 1'b1);

    // Mid-frame reset with three entries buffered.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 11'(60 + i), 1'b0, 1'b0);
    end
    chk_outs("pre_rst", 1'b1, 8'd60, 1'b0, 1'b1, 3'd3, 1'b1);
    bus.valid_in = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk_outs("mid_rst", 1'b0, 8'd0, 1'b0, 1'b1, 3'd0, 1'b0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 11'(70 + i), (i == 15), 1'b1);
      chk_outs($sformatf("post%0d", i), 1'b1, 8'(70 + i), (i == 15), 1'b1, 3'd1, 1'b0);
    end
    step(1'b0, 11'd0, 1'b0, 1'b1);
    chk_outs("post_idle", 1'b0, 8'd0, 1'b0, 1'b1, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
